// File: rtl/car_nav_ctrl_pkg.sv
// Shared types and constants for the line-following navigation sequencer.
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FOLLOW  = 3'd1,
    ST_LOST    = 3'd2,
    ST_SEARCH  = 3'd3,
    ST_BLOCKED = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_OFF = 2'b00;

  localparam logic [2:0] SRCH_L = 3'b110;
  localparam logic [2:0] SRCH_R = 3'b011;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] left;
    logic [1:0] right;
  } drive_t;

  // Pivot toward the side the line was last seen; a centred or full last
  // reading defaults to a left pivot.
  function automatic drive_t search_drive(input logic [2:0] last);
    drive_t d;
    if (last[2] || !last[0]) begin
      d = '{mode: SRCH_L, left: DIR_REV, right: DIR_FWD};
    end else begin
      d = '{mode: SRCH_R, left: DIR_FWD, right: DIR_REV};
    end
    return d;
  endfunction

endpackage

// File: rtl/car_nav_ctrl_sensor_filter.sv
// Per-bit debounce: a bit only takes a new value after FILT_N consecutive
// ticks of disagreement with its current filtered value.
module sensor_filter #(
  parameter int FILT_N = 4,
  parameter int W      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] filt
);

  localparam int RW = $clog2(FILT_N + 1);

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [RW-1:0] run_q;
    logic          filt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        run_q  <= '0;
        filt_q <= 1'b0;
      end else if (tick) begin
        if (raw[b] == filt_q) begin
          run_q <= '0;
        end else if (run_q >= RW'(FILT_N - 1)) begin
          filt_q <= raw[b];
          run_q  <= '0;
        end else begin
          run_q <= run_q + 1'b1;
        end
      end
    end

    assign filt[b] = filt_q;
  end

endmodule

// File: rtl/car_nav_ctrl.sv
// Navigation sequencer: filters IR line sensors, follows the line, searches
// when it is lost and stops for obstacles. Outputs lag the state by one clk.
module car_nav_ctrl
  import car_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int FILT_N       = 4,
  parameter int LOST_TICKS   = 300,
  parameter int SEARCH_TICKS = 1500,
  parameter int RESUME_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] sensors,
  input  logic       obstacle,
  output logic [2:0] mode,
  output logic [1:0] left,
  output logic [1:0] right,
  output logic       motor_stop,
  output logic [2:0] state_dbg
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int TMAX = (LOST_TICKS > SEARCH_TICKS) ? LOST_TICKS : SEARCH_TICKS;
  localparam int TMW  = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam int CW   = (RESUME_TICKS < 1) ? 1 : $clog2(RESUME_TICKS + 1);

  logic [TW-1:0]  tick_cnt_q;
  logic           tick;
  logic [2:0]     filt;

  state_e         state_q, state_d;
  logic [TMW-1:0] timer_q, timer_d, timer_inc, timer_lim;
  logic [CW-1:0]  clear_q, clear_d, clear_inc;
  logic [2:0]     last_q, last_d;
  drive_t         drv_q, drv_d;
  logic           stop_q, stop_d;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  sensor_filter #(
    .FILT_N (FILT_N),
    .W      (3)
  ) u_filter (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .raw  (sensors),
    .filt (filt)
  );

  assign timer_inc = timer_q + 1'b1;
  assign clear_inc = clear_q + 1'b1;
  assign timer_lim = (state_q == ST_LOST) ? TMW'(LOST_TICKS) : TMW'(SEARCH_TICKS);

  // Next state: enable has top priority, then obstacle, then line events.
  // Recovering the line is checked before timer expiry so it wins a tie.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    clear_d = clear_q;
    last_d  = last_q;

    if (state_q == ST_FOLLOW && filt != 3'b000) begin
      last_d = filt;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      timer_d = '0;
      clear_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FOLLOW;
          timer_d = '0;
          clear_d = '0;
        end
        ST_FOLLOW: begin
          if (obstacle) begin
            state_d = ST_BLOCKED;
            timer_d = '0;
            clear_d = '0;
          end else if (filt == 3'b000) begin
            state_d = ST_LOST;
            timer_d = '0;
          end
        end
        ST_LOST, ST_SEARCH: begin
          if (obstacle) begin
            state_d = ST_BLOCKED;
            timer_d = '0;
            clear_d = '0;
          end else if (filt != 3'b000) begin
            state_d = ST_FOLLOW;
            timer_d = '0;
          end else if (tick) begin
            if (timer_inc >= timer_lim) begin
              state_d = (state_q == ST_LOST) ? ST_SEARCH : ST_HALT;
              timer_d = '0;
            end else begin
              timer_d = timer_inc;
            end
          end
        end
        ST_BLOCKED: begin
          if (obstacle) begin
            clear_d = '0;
          end else if (tick) begin
            if (clear_inc >= CW'(RESUME_TICKS)) begin
              state_d = ST_FOLLOW;
              clear_d = '0;
            end else begin
              clear_d = clear_inc;
            end
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
          clear_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    drv_d = '{mode: 3'b000, left: DIR_OFF, right: DIR_OFF};
    case (state_q)
      ST_FOLLOW: drv_d = '{mode: filt, left: DIR_FWD, right: DIR_FWD};
      ST_LOST:   drv_d = '{mode: last_q, left: DIR_FWD, right: DIR_FWD};
      ST_SEARCH: drv_d = search_drive(last_q);
      default:   drv_d = '{mode: 3'b000, left: DIR_OFF, right: DIR_OFF};
    endcase
    // The PWM block is held in reset whenever the speed code is zero.
    stop_d = (drv_d.mode == 3'b000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      clear_q <= '0;
      last_q  <= 3'b010;
      drv_q   <= '{mode: 3'b000, left: DIR_OFF, right: DIR_OFF};
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      clear_q <= clear_d;
      last_q  <= last_d;
      drv_q   <= drv_d;
      stop_q  <= stop_d;
    end
  end

  assign mode       = drv_q.mode;
  assign left       = drv_q.left;
  assign right      = drv_q.right;
  assign motor_stop = stop_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_car_nav_ctrl.sv
// Bench for car_nav_ctrl: directed vector table, async-reset sequence and a
// randomized run checked every clk against a behavioural model.
module tb_car_nav_ctrl;

  localparam int TD = 4;
  localparam int FN = 2;
  localparam int LT = 3;
  localparam int SR = 5;
  localparam int RT = 2;

  localparam int S_IDLE = 0, S_FOLLOW = 1, S_LOST = 2, S_SEARCH = 3, S_BLOCKED = 4, S_HALT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       obstacle = 1'b0;
  logic [2:0] sensors = 3'b000;
  logic [2:0] mode;
  logic [1:0] left;
  logic [1:0] right;
  logic       motor_stop;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  car_nav_ctrl #(
    .TICK_DIV     (TD),
    .FILT_N       (FN),
    .LOST_TICKS   (LT),
    .SEARCH_TICKS (SR),
    .RESUME_TICKS (RT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sensors    (sensors),
    .obstacle   (obstacle),
    .mode       (mode),
    .left       (left),
    .right      (right),
    .motor_stop (motor_stop),
    .state_dbg  (state_dbg)
  );

  // Behavioural model: whole-system state advanced once per clk.
  typedef struct packed {
    int         cnt;
    int         st;
    int         timer;
    int         clear;
    int         r2;
    int         r1;
    int         r0;
    logic [2:0] filt;
    logic [2:0] last;
    logic [2:0] mode;
    logic [1:0] l;
    logic [1:0] r;
    logic       stop;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t reset_mdl();
    mdl_t z;
    z = '0;
    z.st   = S_IDLE;
    z.last = 3'b010;
    z.stop = 1'b1;
    return z;
  endfunction

  function automatic void fbit(input int run, input logic raw, input logic cur,
                               output int run_n, output logic nxt);
    nxt = cur;
    if (raw == cur) begin
      run_n = 0;
    end else begin
      run_n = run + 1;
      if (run_n >= FN) begin
        nxt   = raw;
        run_n = 0;
      end
    end
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic en, input logic [2:0] sn, input logic ob);
    mdl_t n;
    bit   tk;
    int   ra;
    logic fa;
    n  = s;
    tk = (s.cnt == TD - 1);
    n.cnt = tk ? 0 : s.cnt + 1;
    if (tk) begin
      fbit(s.r0, sn[0], s.filt[0], ra, fa); n.r0 = ra; n.filt[0] = fa;
      fbit(s.r1, sn[1], s.filt[1], ra, fa); n.r1 = ra; n.filt[1] = fa;
      fbit(s.r2, sn[2], s.filt[2], ra, fa); n.r2 = ra; n.filt[2] = fa;
    end
    n.mode = 3'b000; n.l = 2'b00; n.r = 2'b00;
    if (s.st == S_FOLLOW) begin
      n.mode = s.filt; n.l = 2'b10; n.r = 2'b10;
    end else if (s.st == S_LOST) begin
      n.mode = s.last; n.l = 2'b10; n.r = 2'b10;
    end else if (s.st == S_SEARCH) begin
      if (s.last[2] || s.last == 3'b010) begin
        n.mode = 3'b110; n.l = 2'b01; n.r = 2'b10;
      end else begin
        n.mode = 3'b011; n.l = 2'b10; n.r = 2'b01;
      end
    end
    n.stop = (n.mode == 3'b000);
    if (s.st == S_FOLLOW && s.filt != 3'b000) n.last = s.filt;
    if (!en) begin
      n.st = S_IDLE; n.timer = 0; n.clear = 0;
    end else if (s.st == S_IDLE) begin
      n.st = S_FOLLOW; n.timer = 0; n.clear = 0;
    end else if (s.st == S_HALT) begin
      n.st = S_HALT;
    end else if (ob && s.st != S_BLOCKED) begin
      n.st = S_BLOCKED; n.timer = 0; n.clear = 0;
    end else if (s.st == S_FOLLOW) begin
      if (s.filt == 3'b000) begin n.st = S_LOST; n.timer = 0; end
    end else if (s.st == S_LOST || s.st == S_SEARCH) begin
      if (s.filt != 3'b000) begin
        n.st = S_FOLLOW; n.timer = 0;
      end else if (tk) begin
        n.timer = s.timer + 1;
        if (n.timer >= ((s.st == S_LOST) ? LT : SR)) begin
          n.st = (s.st == S_LOST) ? S_SEARCH : S_HALT;
          n.timer = 0;
        end
      end
    end else if (s.st == S_BLOCKED) begin
      if (ob) n.clear = 0;
      else if (tk) begin
        n.clear = s.clear + 1;
        if (n.clear >= RT) begin n.st = S_FOLLOW; n.clear = 0; end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= reset_mdl();
    else      m <= step(m, enable, sensors, obstacle);
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({state_dbg, mode, left, right, motor_stop} !== {3'(m.st), m.mode, m.l, m.r, m.stop}) begin
        errors++;
        $display("FAIL model t=%0t: got st=%0d mode=%b l=%b r=%b stop=%b, want st=%0d mode=%b l=%b r=%b stop=%b",
                 $time, state_dbg, mode, left, right, motor_stop, m.st, m.mode, m.l, m.r, m.stop);
      end
    end
  end

  task automatic chk(input string nm, input logic [2:0] st, input logic [2:0] md,
                     input logic [1:0] l, input logic [1:0] r, input logic ms);
    checks++;
    if ({state_dbg, mode, left, right, motor_stop} !== {st, md, l, r, ms}) begin
      errors++;
      $display("FAIL %s: got st=%0d mode=%b l=%b r=%b stop=%b, want st=%0d mode=%b l=%b r=%b stop=%b",
               nm, state_dbg, mode, left, right, motor_stop, st, md, l, r, ms);
    end
  endtask

  typedef struct {
    logic       en;
    logic [2:0] s;
    logic       ob;
    int         n;
    logic [2:0] st;
    logic [2:0] md;
    logic [1:0] l;
    logic [1:0] r;
    logic       ms;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1'b0, 3'b010, 1'b0, 20, 3'd0, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[1]  = '{1'b1, 3'b010, 1'b0,  1, 3'd1, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[2]  = '{1'b1, 3'b010, 1'b0,  1, 3'd1, 3'b010, 2'b10, 2'b10, 1'b0};
    tbl[3]  = '{1'b1, 3'b111, 1'b0,  4, 3'd1, 3'b010, 2'b10, 2'b10, 1'b0};
    tbl[4]  = '{1'b1, 3'b010, 1'b0,  4, 3'd1, 3'b010, 2'b10, 2'b10, 1'b0};
    tbl[5]  = '{1'b1, 3'b100, 1'b0, 12, 3'd1, 3'b100, 2'b10, 2'b10, 1'b0};
    tbl[6]  = '{1'b1, 3'b000, 1'b0, 10, 3'd2, 3'b100, 2'b10, 2'b10, 1'b0};
    tbl[7]  = '{1'b1, 3'b000, 1'b0, 16, 3'd3, 3'b110, 2'b01, 2'b10, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 1'b0, 24, 3'd5, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[9]  = '{1'b0, 3'b000, 1'b0,  2, 3'd0, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[10] = '{1'b0, 3'b001, 1'b0, 12, 3'd0, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[11] = '{1'b1, 3'b001, 1'b0,  4, 3'd1, 3'b001, 2'b10, 2'b10, 1'b0};
    tbl[12] = '{1'b1, 3'b000, 1'b0, 26, 3'd3, 3'b011, 2'b10, 2'b01, 1'b0};
    tbl[13] = '{1'b1, 3'b001, 1'b0, 12, 3'd1, 3'b001, 2'b10, 2'b10, 1'b0};
    tbl[14] = '{1'b1, 3'b001, 1'b1,  2, 3'd4, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[15] = '{1'b1, 3'b001, 1'b0,  4, 3'd4, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[16] = '{1'b1, 3'b001, 1'b1,  2, 3'd4, 3'b000, 2'b00, 2'b00, 1'b1};
    tbl[17] = '{1'b1, 3'b001, 1'b0, 12, 3'd1, 3'b001, 2'b10, 2'b10, 1'b0};

    rst = 1'b0; enable = 1'b0; sensors = 3'b010; obstacle = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold", 3'd0, 3'b000, 2'b00, 2'b00, 1'b1);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      enable   = tbl[i].en;
      sensors  = tbl[i].s;
      obstacle = tbl[i].ob;
      repeat (tbl[i].n) @(negedge clk);
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].md, tbl[i].l, tbl[i].r, tbl[i].ms);
    end

    // Reset asserted between clock edges must act at once.
    sensors = 3'b000;
    repeat (26) @(negedge clk);
    chk("search_before_reset", 3'd3, 3'b011, 2'b10, 2'b01, 1'b0);
    #1 rst = 1'b0;
    #1 chk("async_reset", 3'd0, 3'b000, 2'b00, 2'b00, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Line drop and obstacle arriving together must end in BLOCKED.
    enable = 1'b1; sensors = 3'b010;
    repeat (12) @(negedge clk);
    sensors = 3'b000;
    while (dut.filt != 3'b000 && checks < 100000) @(negedge clk);
    obstacle = 1'b1;
    repeat (2) @(negedge clk);
    chk("drop_and_obstacle", 3'd4, 3'b000, 2'b00, 2'b00, 1'b1);
    obstacle = 1'b0;

    for (int k = 0; k < 400; k++) begin
      enable   = ($urandom_range(0, 19) != 0);
      obstacle = ($urandom_range(0, 5) == 0);
      sensors  = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/car_nav_ctrl.md
Name: car_nav_ctrl

Overview:
Navigation sequencer for the line-following car. Sits between the raw IR line sensors and ultrasonic stop flag on one side, and the motor PWM block and H-bridge direction pins on the other. Filters the sensors and follows the line. Holds the last heading briefly when the line is lost, then pivots to search, and halts if search fails. Stops for obstacles and resumes only after the path has been clear for a set time.

Parameters:
TICK_DIV, 100000, clk cycles per sample tick (1 kHz at 100 MHz); must be >= 2.
FILT_N, 4, consecutive equal tick samples required to accept a new sensor bit value; must be >= 1.
LOST_TICKS, 300, ticks the last heading is held after the line disappears.
SEARCH_TICKS, 1500, ticks of pivot search before halting.
RESUME_TICKS, 500, consecutive obstacle-clear ticks required before leaving BLOCKED.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  run switch, level (SW15)
sensors  in  3  raw {left, mid, right} IR, 1 = line seen
obstacle  in  1  ultrasonic stop flag, level
mode  out  3  motor speed code to the PWM block
left  out  2  left H-bridge direction: 10 fwd, 01 rev, 00 off
right  out  2  right H-bridge direction, same coding
motor_stop  out  1  holds the PWM block in reset
state_dbg  out  3  current state encoding, for LEDs

Behaviour:
- Reset (rst=0, async): state=IDLE; filt=000; last=010; all counters 0; mode=000; left=right=00; motor_stop=1; state_dbg=IDLE.
- Tick: free-running counter 0..TICK_DIV-1; a one-cycle tick pulse fires when the counter reaches TICK_DIV-1. All sampling, filtering and timers advance only on tick.
- Filter, per bit:
  - Keep a run counter of consecutive ticks where raw != filt.
  - Reset the run counter to 0 on any tick where raw == filt.
  - When the run counter reaches FILT_N, set filt to raw and clear the counter.
  - A glitch shorter than FILT_N ticks never changes filt.
- last: loaded with filt whenever filt != 000 in FOLLOW.
- Priority, evaluated every clk: enable=0 beats obstacle beats normal transitions.
- State encoding: IDLE=0, FOLLOW=1, LOST=2, SEARCH=3, BLOCKED=4, HALT=5.
- States and outputs (outputs registered; 1 clk after the state/filt change):
  - IDLE: mode 000, dirs 00, motor_stop=1. Exit to FOLLOW when enable=1.
  - FOLLOW: mode=filt, left=right=10, motor_stop=0. Go to LOST with timer=0 when filt==000. Go to BLOCKED with timer=0 when obstacle=1.
  - LOST: mode=last, dirs 10. If filt != 000, go to FOLLOW. Otherwise the timer increments per tick; go to SEARCH with timer=0 when the timer reaches LOST_TICKS.
  - SEARCH: pivots toward the last side seen.
    - last[2]=1 (including 111): mode 110, left=01, right=10.
    - Else last[0]=1: mode 011, left=10, right=01.
    - Else (010): same as last[2]=1.
    - Exit to FOLLOW when filt != 000. Go to HALT when the timer reaches SEARCH_TICKS.
  - BLOCKED: mode 000, dirs 00, motor_stop=1.
    - The clear counter increments on ticks with obstacle=0 and resets to 0 on any clk where obstacle=1.
    - Go to FOLLOW when the counter reaches RESUME_TICKS. If filt==000 at that point, FOLLOW moves to LOST on the next clk.
  - HALT: outputs as IDLE. Stays until enable=0, then IDLE. Re-raising enable is required to restart.
- enable=0 in any state: go to IDLE next clk and clear timers. The filter keeps running.
- obstacle=1 in LOST or SEARCH also goes to BLOCKED. Obstacle is ignored in IDLE and HALT.
- Simultaneous events:
  - filt→000 and obstacle=1 in the same clk: BLOCKED.
  - Timer expiry and filt != 000 in the same tick: FOLLOW wins.
- Invariant: motor_stop=1 exactly when mode==000.
- Counters saturate and never wrap.

Decomposition:
- Package car_pkg holds:
  - the state enum (3-bit, encoding above);
  - direction constants DIR_FWD=2'b10, DIR_REV=2'b01, DIR_OFF=2'b00;
  - search mode codes SRCH_L=3'b110, SRCH_R=3'b011.
- One sub-module, sensor_filter: parameter FILT_N and width 3; inputs clk, rst, tick, raw; output filt. It is instantiated once.

Test Plan (sim params TICK_DIV=4, FILT_N=2, LOST_TICKS=3, SEARCH_TICKS=5, RESUME_TICKS=2):
- Release rst, hold enable=0, sensors=010 for 20 clk -> state_dbg=0, mode=000, motor_stop=1. Then enable=1 -> FOLLOW next clk; mode=010 after 2 ticks; left=right=10.
- In FOLLOW at 010, pulse sensors=111 for 1 tick -> mode stays 010. Hold 100 for 2 ticks -> mode=100, last=100.
- From last=100, sensors=000 -> LOST with mode=100 for 3 ticks, then SEARCH with mode=110, left=01, right=10. After 5 more ticks -> HALT, mode=000. Drop enable -> IDLE.
- In SEARCH (last=001), sensors=001 held 2 ticks -> FOLLOW, mode=001.
- In FOLLOW, obstacle=1 -> BLOCKED, mode=000, motor_stop=1. Clear for 1 tick then re-assert -> still BLOCKED. Clear for 2 ticks -> FOLLOW.
- Assert rst mid-SEARCH -> all outputs at reset values immediately, with no clk edge needed.
